// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - generic valid/ready inter-stage pipeline register
//
// Carries an opaque DATA_W payload between CPU stages. It supports a valid/ready
// handshake, flush (bubble insertion) and a saturating stall counter.
//
// Build option: define PIPE_SKID_EN for the two-entry skid build. In that build
// in_ready is registered, so it never depends combinationally on out_ready.
// When the macro is undefined, the block is a single-entry register with the
// classic in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   flush                drop every held entry and any payload offered this cycle
//   in_valid/in_ready    upstream handshake, with payload in_data
//   out_valid/out_ready  downstream handshake, with payload out_data
//   stall_cnt            saturating count of cycles with out_valid && !out_ready
//   stall_clr            synchronous clear of stall_cnt (wins over increment)

module pipe_stage #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  stall_q;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transfer
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (in_fire) state_d = S_ONE;
        S_ONE: begin
          if (in_fire && !out_fire) begin
`ifdef PIPE_SKID_EN
            state_d = S_TWO;
`else
            state_d = S_ONE;
`endif
          end else if (!in_fire && out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO:   if (out_fire) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Outputs decoded from state and storage
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    out_data  = data_q;
`ifdef PIPE_SKID_EN
    in_ready  = ready_q;
`else
    in_ready  = !out_valid || out_ready;
`endif
  end

  // Payload steering. The output register only changes on fill, out_fire,
  // flush or rst, so it stays stable while the stage is stalled.
  always_comb begin
    data_d = data_q;
`ifdef PIPE_SKID_EN
    skid_d = skid_q;
`endif
    if (flush) begin
      data_d = RESET_VAL;
    end else begin
      case (state_q)
        S_EMPTY: if (in_fire) data_d = in_data;
        S_ONE: begin
          if (in_fire && out_fire) begin
            data_d = in_data;
          end
`ifdef PIPE_SKID_EN
          else if (in_fire) begin
            skid_d = in_data;
          end
`endif
        end
        S_TWO: begin
`ifdef PIPE_SKID_EN
          if (out_fire) data_d = skid_q;
`endif
        end
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

`ifdef PIPE_SKID_EN
  // The skid contents need no reset: the state machine says whether they are live.
  // in_ready is registered from the next state, so it is known before out_ready arrives.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
    if (rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != S_TWO);
    end
  end
`endif

  // Stall counter: saturating; clear wins; flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst || stall_clr) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - directed vector bench for pipe_stage
module tb_pipe_stage;

  localparam int          DW = 8;
  localparam logic [7:0]  RV = 8'h5A;
  localparam int          CW = 2;
`ifdef PIPE_SKID_EN
  localparam logic SK = 1'b1;
`else
  localparam logic SK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  typedef struct {
    logic       rst, flush, iv;
    logic [7:0] d;
    logic       ordy, clr;
    logic       ov;
    logic [7:0] od;
    logic       chk_d, ir;
    logic [1:0] sc;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, then sample 1 ns after the edge.
  task automatic step(input string nm, input logic r, input logic f, input logic iv,
                      input logic [7:0] d, input logic ordy, input logic clr,
                      input logic ov, input logic [7:0] od, input logic chk_d,
                      input logic ir, input logic [1:0] sc);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy; stall_clr = clr;
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
    if (chk_d) chk({nm, ".out_data"}, 32'(out_data), 32'(od));
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(ir));
    chk({nm, ".stall_cnt"}, 32'(stall_cnt), 32'(sc));
  endtask

  initial begin
    // rst flush iv  d      ordy clr  ov  od    chk_d ir  sc
    tbl[0]  = '{1, 0, 0, 8'h00, 1, 0, 0, RV,    1, 1,  2'd0};
    tbl[1]  = '{1, 0, 0, 8'h00, 1, 0, 0, RV,    1, 1,  2'd0};
    tbl[2]  = '{0, 0, 1, 8'h10, 1, 0, 1, 8'h10, 1, 1,  2'd0};
    tbl[3]  = '{0, 0, 1, 8'h11, 1, 0, 1, 8'h11, 1, 1,  2'd0};
    tbl[4]  = '{0, 0, 1, 8'h12, 1, 0, 1, 8'h12, 1, 1,  2'd0};
    tbl[5]  = '{0, 0, 0, 8'hxx, 1, 0, 0, 8'h00, 0, 1,  2'd0};
    tbl[6]  = '{0, 0, 1, 8'h20, 1, 0, 1, 8'h20, 1, 1,  2'd0};
    tbl[7]  = '{0, 1, 1, 8'h0C, 1, 0, 0, RV,    1, 1,  2'd0};
    tbl[8]  = '{0, 0, 0, 8'hxx, 1, 0, 0, RV,    1, 1,  2'd0};
    tbl[9]  = '{0, 0, 1, 8'h21, 1, 0, 1, 8'h21, 1, 1,  2'd0};
    tbl[10] = '{1, 0, 1, 8'h22, 1, 0, 0, RV,    1, 1,  2'd0};
    tbl[11] = '{0, 0, 1, 8'h23, 1, 0, 1, 8'h23, 1, 1,  2'd0};
    tbl[12] = '{0, 0, 0, 8'hxx, 0, 0, 1, 8'h23, 1, SK, 2'd1};
    tbl[13] = '{0, 0, 0, 8'hxx, 0, 1, 1, 8'h23, 1, SK, 2'd0};
    tbl[14] = '{0, 0, 0, 8'hxx, 0, 0, 1, 8'h23, 1, SK, 2'd1};
    tbl[15] = '{0, 0, 0, 8'hxx, 1, 0, 0, 8'h00, 0, 1,  2'd1};
    tbl[16] = '{0, 1, 0, 8'hxx, 1, 0, 0, RV,    1, 1,  2'd1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; stall_clr = 1'b0;
    #1;

    for (int i = 0; i < 17; i++) begin
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d,
           tbl[i].ordy, tbl[i].clr, tbl[i].ov, tbl[i].od, tbl[i].chk_d, tbl[i].ir, tbl[i].sc);
    end

    // Stall counter saturation at CNT_W=2, then clear
    step("sat_load", 0, 0, 1, 8'h30, 0, 1, 1, 8'h30, 1, SK, 2'd0);
    for (int k = 0; k < 6; k++) begin
      step($sformatf("sat%0d", k), 0, 0, 0, 8'hxx, 0, 0, 1, 8'h30, 1, SK,
           (k < 2) ? 2'(k + 1) : 2'd3);
    end
    step("sat_clr", 0, 0, 0, 8'hxx, 0, 1, 1, 8'h30, 1, SK, 2'd0);
    step("sat_drain", 0, 0, 0, 8'hxx, 1, 0, 0, 8'h00, 0, 1, 2'd0);

`ifdef PIPE_SKID_EN
    // Skid back-pressure: two entries held, in_ready registered low while full
    step("skid_a", 0, 0, 1, 8'h0A, 0, 0, 1, 8'h0A, 1, 1, 2'd0);
    step("skid_b", 0, 0, 1, 8'h0B, 0, 0, 1, 8'h0A, 1, 0, 2'd1);
    step("skid_hold", 0, 0, 0, 8'hxx, 0, 0, 1, 8'h0A, 1, 0, 2'd2);
    step("skid_out_a", 0, 0, 0, 8'hxx, 1, 0, 1, 8'h0B, 1, 1, 2'd2);
    step("skid_out_b", 0, 0, 0, 8'hxx, 1, 0, 0, 8'h00, 0, 1, 2'd2);
    // Flush while TWO, with 0xC offered
    step("skfl_a", 0, 0, 1, 8'h0A, 0, 1, 1, 8'h0A, 1, 1, 2'd0);
    step("skfl_b", 0, 0, 1, 8'h0B, 0, 0, 1, 8'h0A, 1, 0, 2'd1);
    step("skfl_flush", 0, 1, 1, 8'h0C, 0, 0, 0, RV, 1, 1, 2'd2);
    step("skfl_after", 0, 0, 0, 8'hxx, 1, 0, 0, RV, 1, 1, 2'd2);
`else
    // Single-entry back-pressure: in_ready follows out_ready combinationally
    step("ns_a", 0, 0, 1, 8'h0A, 0, 0, 1, 8'h0A, 1, 0, 2'd0);
    step("ns_b", 0, 0, 1, 8'h0B, 0, 0, 1, 8'h0A, 1, 0, 2'd1);
    out_ready = 1'b1;
    #1;
    chk("ns_comb_ready", 32'(in_ready), 32'd1);
    step("ns_c", 0, 0, 1, 8'h0B, 1, 0, 1, 8'h0B, 1, 1, 2'd1);
    step("ns_d", 0, 0, 0, 8'hxx, 1, 0, 0, 8'h00, 0, 1, 2'd1);
    // Flush with 0xC offered
    step("nsfl_a", 0, 0, 1, 8'h0A, 0, 0, 1, 8'h0A, 1, 0, 2'd1);
    step("nsfl_flush", 0, 1, 1, 8'h0C, 0, 0, 0, RV, 1, 1, 2'd2);
    step("nsfl_after", 0, 0, 0, 8'hxx, 1, 0, 0, RV, 1, 1, 2'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
